fetch_ctrl: RTL and testbench

//   Sequences the IF stage: owns the fetch address and drives the PC register's

---
 rtl/fetch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the fetch address, drives next-PC/stall_F, runs the imem handshake.
// Optional rvalid timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_D_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_next_o,
    output logic        stall_F_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        fetch_err_o
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        req;
    logic        stall_f;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic [31:0] addr_inc;

`ifdef FETCH_TIMEOUT_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           fetch_err_q, fetch_err_d;
`else
    localparam int unsigned UNUSED_MAX_WAIT = MAX_WAIT;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign target   = {redirect_pc_i[31:2], 2'b00};
    assign addr_inc = fetch_addr_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        kill_d        = kill_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        req           = 1'b0;
        stall_f       = 1'b1;
        pc_next       = fetch_addr_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        fetch_err_d   = 1'b0;
`endif
        case (state_q)
            S_BOOT: begin
                stall_f = 1'b0;
                pc_next = RESET_VEC;
                state_d = S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (redirect_valid_i) begin
                    fetch_addr_d = target;
                    stall_f      = 1'b0;
                    pc_next      = target;
                    // A granted request to the stale address is still in flight.
                    if (imem_gnt_i) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_gnt_i) begin
                    state_d = S_WAIT;
                end
`ifdef FETCH_TIMEOUT_EN
                if (imem_gnt_i) wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    fetch_addr_d = target;
                    stall_f      = 1'b0;
                    pc_next      = target;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d       = imem_rdata_i;
                        instr_valid_d = 1'b1;
                        if (!stall_D_i) begin
                            fetch_addr_d = addr_inc;
                            stall_f      = 1'b0;
                            pc_next      = addr_inc;
                            state_d      = S_REQ;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
                    // Give up and re-request; the late response gets killed.
                    fetch_err_d = 1'b1;
                    kill_d      = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (redirect_valid_i) begin
                    fetch_addr_d = target;
                    stall_f      = 1'b0;
                    pc_next      = target;
                    state_d      = S_REQ;
                end else if (!stall_D_i) begin
                    fetch_addr_d = addr_inc;
                    stall_f      = 1'b0;
                    pc_next      = addr_inc;
                    state_d      = S_REQ;
                end else begin
                    instr_valid_d = 1'b1;
                end
            end
            default: state_d = S_BOOT;
        endcase
        // Hold the PC register at the reset vector while reset is asserted.
        if (!rst) begin
            req     = 1'b0;
            stall_f = 1'b1;
            pc_next = RESET_VEC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            fetch_addr_q  <= RESET_VEC;
            kill_q        <= 1'b0;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q    <= '0;
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            kill_q        <= kill_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            fetch_err_q   <= fetch_err_d;
`endif
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_addr_q;
    assign pc_next_o     = pc_next;
    assign stall_F_o     = stall_f;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err_o   = fetch_err_q;
`else
    assign fetch_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle vector table for the handshake/redirect corners,
// then a reactive random memory with an in-order instruction scoreboard.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        stall_D_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] pc_next_o;
    logic        stall_F_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        fetch_err_o;

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .stall_D_i(stall_D_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .pc_next_o(pc_next_o), .stall_F_o(stall_F_o),
        .instr_o(instr_o), .instr_valid_o(instr_valid_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        stall_d;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall_f;
        logic [31:0] e_pc_next;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;
    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0004, D2 = 32'h0000_0013;
    localparam logic [31:0] D3 = 32'h4444_000C, D4 = 32'hBAD0_0100, D5 = 32'h5555_0300;
    localparam logic [31:0] D6 = 32'h6666_FFFC, JK = 32'hDEAD_BEEF, Z = 32'h0;
    localparam logic [31:0] MASK = 32'h5A5A_0000;
    localparam int NV = 29;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [NV];
    logic [31:0] sb [$];

    function automatic vec_t row(input logic r, input logic [31:0] rpc, input logic sd,
                                 input logic g, input logic rv, input logic [31:0] rd,
                                 input logic er, input logic [31:0] ea, input logic es,
                                 input logic [31:0] ep, input logic ev, input logic [31:0] ei);
        vec_t v;
        v.redir = r; v.rpc = rpc; v.stall_d = sd; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_stall_f = es; v.e_pc_next = ep;
        v.e_valid = ev; v.e_instr = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; stall_D_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    endtask

    // Leaves the bench at posedge+1 of the BOOT cycle with rst released.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check({tag, ".req"},   32'(imem_req_o),    32'h0);
        check({tag, ".stf"},   32'(stall_F_o),     32'h1);
        check({tag, ".pcn"},   pc_next_o,          32'h0);
        check({tag, ".vld"},   32'(instr_valid_o), 32'h0);
        check({tag, ".instr"}, instr_o,            32'h0);
        check({tag, ".err"},   32'(fetch_err_o),   32'h0);
        $display("[TB] %s: reset outputs checked", tag);
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] paddr;
        logic [31:0] exp_instr;
        logic        pending;
        logic        prev_valid;
        int          cnt;
        int          deliveries;

        tbl[0]  = row(L, Z,       L, L, L, Z,  L, Z,       L, Z,       L, Z);
        tbl[1]  = row(L, Z,       L, H, L, Z,  H, Z,       H, Z,       L, Z);
        tbl[2]  = row(L, Z,       L, L, H, D0, L, Z,       L, 32'h4,   L, Z);
        tbl[3]  = row(L, Z,       L, H, L, Z,  H, 32'h4,   H, Z,       H, D0);
        tbl[4]  = row(L, Z,       L, L, H, D1, L, 32'h4,   L, 32'h8,   L, Z);
        tbl[5]  = row(L, Z,       L, H, L, Z,  H, 32'h8,   H, Z,       H, D1);
        tbl[6]  = row(L, Z,       H, L, H, D2, L, 32'h8,   H, Z,       L, Z);
        tbl[7]  = row(L, Z,       H, L, L, Z,  L, 32'h8,   H, Z,       H, D2);
        tbl[8]  = row(L, Z,       H, L, L, Z,  L, 32'h8,   H, Z,       H, D2);
        tbl[9]  = row(L, Z,       L, L, L, Z,  L, 32'h8,   L, 32'hC,   H, D2);
        tbl[10] = row(L, Z,       L, L, L, Z,  H, 32'hC,   H, Z,       L, Z);
        tbl[11] = row(L, Z,       L, H, L, Z,  H, 32'hC,   H, Z,       L, Z);
        tbl[12] = row(L, Z,       L, L, L, Z,  L, 32'hC,   H, Z,       L, Z);
        tbl[13] = row(L, Z,       L, L, H, D3, L, 32'hC,   L, 32'h10,  L, Z);
        tbl[14] = row(H, 32'h20,  L, L, L, Z,  H, 32'h10,  L, 32'h20,  H, D3);
        tbl[15] = row(L, Z,       L, H, L, Z,  H, 32'h20,  H, Z,       L, Z);
        tbl[16] = row(H, 32'h103, L, L, L, Z,  L, 32'h20,  L, 32'h100, L, Z);
        tbl[17] = row(L, Z,       L, L, L, Z,  L, 32'h100, H, Z,       L, Z);
        tbl[18] = row(L, Z,       L, L, H, JK, L, 32'h100, H, Z,       L, Z);
        tbl[19] = row(L, Z,       L, H, L, Z,  H, 32'h100, H, Z,       L, Z);
        tbl[20] = row(H, 32'h200, L, L, H, D4, L, 32'h100, L, 32'h200, L, Z);
        tbl[21] = row(H, 32'h300, L, H, L, Z,  H, 32'h200, L, 32'h300, L, Z);
        tbl[22] = row(L, Z,       L, L, H, JK, L, 32'h300, H, Z,       L, Z);
        tbl[23] = row(L, Z,       L, H, L, Z,  H, 32'h300, H, Z,       L, Z);
        tbl[24] = row(L, Z,       H, L, H, D5, L, 32'h300, H, Z,       L, Z);
        tbl[25] = row(H, 32'hFFFF_FFFC, L, L, L, Z, L, 32'h300, L, 32'hFFFF_FFFC, H, D5);
        tbl[26] = row(L, Z,       L, H, L, Z,  H, 32'hFFFF_FFFC, H, Z, L, Z);
        tbl[27] = row(L, Z,       L, L, H, D6, L, 32'hFFFF_FFFC, L, 32'h0, L, Z);
        tbl[28] = row(L, Z,       L, L, L, Z,  H, 32'h0,   H, Z,       H, D6);

        do_reset("rst0");
        for (int i = 0; i < NV; i++) begin
            redirect_valid_i = tbl[i].redir;  redirect_pc_i = tbl[i].rpc;
            stall_D_i = tbl[i].stall_d;       imem_gnt_i = tbl[i].gnt;
            imem_rvalid_i = tbl[i].rvalid;    imem_rdata_i = tbl[i].rdata;
            @(negedge clk);
            check($sformatf("row%0d.req", i),  32'(imem_req_o),    32'(tbl[i].e_req));
            check($sformatf("row%0d.addr", i), imem_addr_o,        tbl[i].e_addr);
            check($sformatf("row%0d.stf", i),  32'(stall_F_o),     32'(tbl[i].e_stall_f));
            if (!tbl[i].e_stall_f)
                check($sformatf("row%0d.pcn", i), pc_next_o, tbl[i].e_pc_next);
            check($sformatf("row%0d.vld", i),  32'(instr_valid_o), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                check($sformatf("row%0d.instr", i), instr_o, tbl[i].e_instr);
            check($sformatf("row%0d.err", i),  32'(fetch_err_o),   32'h0);
            $display("[TB] row %0d: req=%0b addr=%h stall_F=%0b pc_next=%h valid=%0b instr=%h",
                     i, imem_req_o, imem_addr_o, stall_F_o, pc_next_o, instr_valid_o, instr_o);
            next_cycle();
        end

`ifdef FETCH_TIMEOUT_EN
        // Withheld rvalid: error pulse after 8 WAIT cycles, same address re-requested.
        do_reset("rst_to");
        clear_inputs();
        @(negedge clk); next_cycle();              // BOOT
        imem_gnt_i = 1'b1;
        @(negedge clk);
        check("to.req0", 32'(imem_req_o), 32'h1);
        next_cycle();
        imem_gnt_i = 1'b0;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            check($sformatf("to.wait%0d.err", w), 32'(fetch_err_o), 32'h0);
            check($sformatf("to.wait%0d.req", w), 32'(imem_req_o), 32'h0);
            next_cycle();
        end
        imem_gnt_i = 1'b1;
        @(negedge clk);
        check("to.err_pulse", 32'(fetch_err_o), 32'h1);
        check("to.rereq",     32'(imem_req_o),  32'h1);
        check("to.readdr",    imem_addr_o,      32'h0);
        $display("[TB] timeout: err=%0b re-request addr=%h", fetch_err_o, imem_addr_o);
        next_cycle();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = JK;
        @(negedge clk);
        check("to.err_once", 32'(fetch_err_o), 32'h0);
        next_cycle();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("to.late_vld", 32'(instr_valid_o), 32'h0);
        check("to.late_req", 32'(imem_req_o),    32'h1);
        check("to.late_adr", imem_addr_o,        32'h0);
        next_cycle();
`endif

        // Reactive memory with random gnt/rvalid latency and decode stalls.
        do_reset("rst1");
        exp_addr = 32'h0; pending = 1'b0; prev_valid = 1'b0; cnt = 0; deliveries = 0;
        for (int c = 0; c < 500; c++) begin
            imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_valid_i = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = paddr ^ MASK;
                    sb.push_back(paddr ^ MASK);
                    pending = 1'b0;
                end
            end
            stall_D_i = ($urandom_range(0, 3) == 0);
            if (imem_req_o && !pending && ($urandom_range(0, 3) != 0)) begin
                imem_gnt_i = 1'b1;
                paddr = imem_addr_o;
                check($sformatf("rnd%0d.addr", c), paddr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                pending = 1'b1;
                cnt = int'($urandom_range(1, 3));
            end
            @(negedge clk);
            check($sformatf("rnd%0d.err", c), 32'(fetch_err_o), 32'h0);
            if (instr_valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    check($sformatf("rnd%0d.unexpected", c), 32'(instr_valid_o), 32'h0);
                end else begin
                    exp_instr = sb.pop_front();
                    check($sformatf("rnd%0d.instr", c), instr_o, exp_instr);
                    deliveries++;
                    $display("[TB] delivery %0d: instr=%h expected=%h", deliveries, instr_o, exp_instr);
                end
            end
            prev_valid = instr_valid_o;
            next_cycle();
        end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; stall_D_i = 1'b0;
        for (int c = 0; c < 6 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (instr_valid_o && !prev_valid) begin
                exp_instr = sb.pop_front();
                check("drain.instr", instr_o, exp_instr);
                deliveries++;
            end
            prev_valid = instr_valid_o;
            next_cycle();
        end
        check("sb.empty", 32'(sb.size()), 32'h0);
        check("sb.enough", 32'(deliveries > 20), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
